// File: rtl/mtsp_mem_queue_pkg.sv
// mtsp_mem_queue_pkg: shared widths, request entry, bus beat payload and
// issue FSM state encoding for the MTSP memory request queue.
package mtsp_mem_queue_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned GPR_W  = 6;

  // Active-low target select value meaning "no request this cycle"
  localparam logic [1:0] NEN_IDLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR0  = 2'd2,
    ST_WR1  = 2'd3
  } issue_state_e;

  // One queued execute-stage request
  typedef struct packed {
    logic              id;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [GPR_W-1:0]  src;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
  } mem_req_t;

  localparam int unsigned REQ_W = $bits(mem_req_t);

  // Registered downstream bus beat
  typedef struct packed {
    logic              valid;
    logic              id;
    logic              write;
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_beat_t;

  // Target id from the active-low select: bit 0 low selects target 0
  function automatic logic nen_to_id(input logic [1:0] nen);
    return nen[0];
  endfunction

endpackage

// File: rtl/mtsp_mem_queue_if.sv
// mtsp_mem_queue_if: downstream memory bus between the queue (master) and
// the memory system (slave).
//   BUS_VALID/BUS_READY : beat handshake
//   BUS_ID, BUS_WRITE, BUS_LAST, BUS_ADDR, BUS_WDATA : beat payload
interface mtsp_mem_queue_if;
  import mtsp_mem_queue_pkg::*;

  logic              BUS_VALID;
  logic              BUS_READY;
  logic              BUS_ID;
  logic              BUS_WRITE;
  logic              BUS_LAST;
  logic [ADDR_W-1:0] BUS_ADDR;
  logic [DATA_W-1:0] BUS_WDATA;

  modport master (
    output BUS_VALID, BUS_ID, BUS_WRITE, BUS_LAST, BUS_ADDR, BUS_WDATA,
    input  BUS_READY
  );

  modport slave (
    input  BUS_VALID, BUS_ID, BUS_WRITE, BUS_LAST, BUS_ADDR, BUS_WDATA,
    output BUS_READY
  );

endinterface

// File: rtl/mtsp_sync_fifo.sv
// mtsp_sync_fifo: generic single-clock FIFO with a fall-through head.
//   clk, rst  : clock, synchronous active-high reset
//   push_i    : write wdata_i (ignored when full unless pop_i the same cycle)
//   pop_i     : drop the head entry (ignored when empty)
//   rdata_o   : current head entry (valid while count_o != 0)
//   count_o   : registered occupancy
module mtsp_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  // A full FIFO still accepts when the head leaves in the same cycle
  assign push_ok = push_i && (!full || pop_i);
  assign pop_ok  = pop_i && !empty;

  // Pointer and occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only occupied slots are ever read
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/mtsp_mem_queue.sv
// mtsp_mem_queue: buffers execute-stage memory requests, issues them on the
// downstream bus (reads one beat, writes two beats) and returns read data to
// the register file in order.
//   CLK, RST                       : clock, synchronous active-high reset
//   MEM_nEN/WRITE/ADDR/SRC/DATA_*  : upstream request (MEM_nEN 2'b11 = idle)
//   MEM_STALL                      : back-pressure, from registered occupancy
//   bus (mtsp_mem_queue_if.master) : downstream beat bus
//   RD_VALID, RD_DATA              : in-order read return
//   WB_VALID, WB_GPR, WB_DATA      : register write-back
//   ERR                            : sticky drop / unexpected-return flag
//   STAT_REQ, STAT_STALL           : saturating counters, present only when
//                                    MTSP_MEM_QUEUE_STAT_EN is defined
module mtsp_mem_queue
  import mtsp_mem_queue_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned RD_OUTSTANDING = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [1:0]          MEM_nEN,
  input  logic                MEM_WRITE,
  input  logic [ADDR_W-1:0]   MEM_ADDR,
  input  logic [GPR_W-1:0]    MEM_SRC,
  input  logic [DATA_W-1:0]   MEM_DATA_0,
  input  logic [DATA_W-1:0]   MEM_DATA_1,
  output logic                MEM_STALL,
  mtsp_mem_queue_if.master    bus,
  input  logic                RD_VALID,
  input  logic [DATA_W-1:0]   RD_DATA,
  output logic                WB_VALID,
  output logic [GPR_W-1:0]    WB_GPR,
  output logic [DATA_W-1:0]   WB_DATA,
  output logic                ERR,
  output logic [31:0]         STAT_REQ,
  output logic [31:0]         STAT_STALL
);

  localparam int unsigned REQ_CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned TAG_CNT_W = $clog2(RD_OUTSTANDING + 1);

  issue_state_e          state_q, state_d;
  bus_beat_t             beat_q, beat_d;
  mem_req_t              in_req, req_head, issue_req;
  logic [REQ_CNT_W-1:0]  req_count;
  logic [TAG_CNT_W-1:0]  tag_count;
  logic [GPR_W-1:0]      tag_head;
  logic                  req_valid, req_empty, req_full, req_push_ok, req_pop;
  logic                  issue_avail, tag_empty, tag_full, tag_push, tag_pop;
  logic                  err_q, err_d;
  logic                  wb_valid_q;
  logic [GPR_W-1:0]      wb_gpr_q;
  logic [DATA_W-1:0]     wb_data_q;

  // Upstream request capture
  assign req_valid    = (MEM_nEN != NEN_IDLE);
  assign in_req.id    = nen_to_id(MEM_nEN);
  assign in_req.write = MEM_WRITE;
  assign in_req.addr  = MEM_ADDR;
  assign in_req.src   = MEM_SRC;
  assign in_req.data0 = MEM_DATA_0;
  assign in_req.data1 = MEM_DATA_1;

  assign req_empty   = (req_count == '0);
  assign req_full    = (req_count == REQ_CNT_W'(DEPTH));
  assign req_push_ok = req_valid && (!req_full || req_pop);
  assign MEM_STALL   = (req_count >= REQ_CNT_W'(DEPTH - 1));

  // Pops only happen from the final beat of a transaction
  assign req_pop  = beat_q.valid && bus.BUS_READY &&
                    ((state_q == ST_RD) || (state_q == ST_WR1));
  assign tag_push = beat_q.valid && bus.BUS_READY && (state_q == ST_RD);

  assign tag_empty = (tag_count == '0);
  assign tag_full  = (tag_count == TAG_CNT_W'(RD_OUTSTANDING));
  assign tag_pop   = RD_VALID && !tag_empty;

  // Bypass: a push into an empty FIFO is issued at the same edge it is stored
  assign issue_avail = !req_empty || req_push_ok;
  assign issue_req   = req_empty ? in_req : req_head;

  mtsp_sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push_i  (req_push_ok),
    .pop_i   (req_pop),
    .wdata_i (in_req),
    .rdata_o (req_head),
    .count_o (req_count)
  );

  mtsp_sync_fifo #(
    .WIDTH (GPR_W),
    .DEPTH (RD_OUTSTANDING)
  ) u_tag_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push_i  (tag_push),
    .pop_i   (tag_pop),
    .wdata_i (issue_req.src),
    .rdata_o (tag_head),
    .count_o (tag_count)
  );

  // Issue FSM: next state and next registered bus beat
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    err_d   = err_q || (req_valid && !req_push_ok) || (RD_VALID && tag_empty);
    unique case (state_q)
      ST_IDLE: begin
        beat_d = '0;
        // Reads wait for tag space; writes never do
        if (issue_avail && (issue_req.write || !tag_full)) begin
          state_d      = issue_req.write ? ST_WR0 : ST_RD;
          beat_d.valid = 1'b1;
          beat_d.id    = issue_req.id;
          beat_d.write = issue_req.write;
          beat_d.last  = !issue_req.write;
          beat_d.addr  = issue_req.addr;
          beat_d.wdata = issue_req.write ? issue_req.data0 : '0;
        end
      end
      ST_RD: begin
        if (bus.BUS_READY) begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end
      end
      ST_WR0: begin
        // Head is still the write in flight; it pops after beat 1
        if (bus.BUS_READY) begin
          state_d      = ST_WR1;
          beat_d.last  = 1'b1;
          beat_d.wdata = issue_req.data1;
        end
      end
      ST_WR1: begin
        if (bus.BUS_READY) begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // State, bus, error and write-back registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      err_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_gpr_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      wb_valid_q <= tag_pop;
      if (tag_pop) begin
        wb_gpr_q  <= tag_head;
        wb_data_q <= RD_DATA;
      end
    end
  end

  assign bus.BUS_VALID = beat_q.valid;
  assign bus.BUS_ID    = beat_q.id;
  assign bus.BUS_WRITE = beat_q.write;
  assign bus.BUS_LAST  = beat_q.last;
  assign bus.BUS_ADDR  = beat_q.addr;
  assign bus.BUS_WDATA = beat_q.wdata;

  assign WB_VALID = wb_valid_q;
  assign WB_GPR   = wb_gpr_q;
  assign WB_DATA  = wb_data_q;
  assign ERR      = err_q;

`ifdef MTSP_MEM_QUEUE_STAT_EN
  logic [31:0] stat_req_q, stat_stall_q;

  // Saturating request / stall-cycle counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_req_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      if (req_push_ok && (stat_req_q != '1))  stat_req_q   <= stat_req_q + 32'd1;
      if (MEM_STALL && (stat_stall_q != '1))  stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign STAT_REQ   = stat_req_q;
  assign STAT_STALL = stat_stall_q;
`else
  assign STAT_REQ   = '0;
  assign STAT_STALL = '0;
`endif

endmodule

// File: tb/tb_mtsp_mem_queue.sv
// tb_mtsp_mem_queue: directed stimulus with a queue-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_mtsp_mem_queue;
  import mtsp_mem_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int RDO   = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic [1:0]   MEM_nEN;
  logic         MEM_WRITE;
  logic [31:0]  MEM_ADDR;
  logic [5:0]   MEM_SRC;
  logic [127:0] MEM_DATA_0, MEM_DATA_1;
  logic         MEM_STALL;
  logic         RD_VALID;
  logic [127:0] RD_DATA;
  logic         WB_VALID;
  logic [5:0]   WB_GPR;
  logic [127:0] WB_DATA;
  logic         ERR;
  logic [31:0]  STAT_REQ, STAT_STALL;

  always #5 CLK = ~CLK;

  mtsp_mem_queue_if bus_if ();

  mtsp_mem_queue #(.DEPTH(DEPTH), .RD_OUTSTANDING(RDO)) dut (
    .CLK(CLK), .RST(RST), .MEM_nEN(MEM_nEN), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDR(MEM_ADDR), .MEM_SRC(MEM_SRC), .MEM_DATA_0(MEM_DATA_0),
    .MEM_DATA_1(MEM_DATA_1), .MEM_STALL(MEM_STALL), .bus(bus_if),
    .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .WB_VALID(WB_VALID),
    .WB_GPR(WB_GPR), .WB_DATA(WB_DATA), .ERR(ERR),
    .STAT_REQ(STAT_REQ), .STAT_STALL(STAT_STALL)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic         id;
    logic         wr;
    logic         last;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [5:0]   src;
  } beat_t;

  beat_t        m_beats[$];
  logic [5:0]   m_tags[$];
  int           m_count = 0;
  logic         m_err = 1'b0;
  logic         m_wb_v = 1'b0;
  logic [5:0]   m_wb_gpr = '0;
  logic [127:0] m_wb_data = '0;
  int unsigned  m_stat_req = 0, m_stat_stall = 0;
  logic         m_started = 1'b0, m_rst_seen = 1'b0;
  int           n_rd_acc = 0, n_wr_acc = 0;
  logic         p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
  logic [31:0]  p_addr = '0;
  logic [127:0] p_wdata = '0;

  always @(negedge CLK) begin
    beat_t b;
    logic  pop;
    if (m_started) begin
      chk("mem_stall", 128'(MEM_STALL), 128'(m_count >= DEPTH - 1));
      chk("err", 128'(ERR), 128'(m_err));
      chk("wb_valid", 128'(WB_VALID), 128'(m_wb_v));
      if (m_wb_v) begin
        chk("wb_gpr", 128'(WB_GPR), 128'(m_wb_gpr));
        chk("wb_data", WB_DATA, m_wb_data);
      end
`ifdef MTSP_MEM_QUEUE_STAT_EN
      chk("stat_req", 128'(STAT_REQ), 128'(m_stat_req));
      chk("stat_stall", 128'(STAT_STALL), 128'(m_stat_stall));
`else
      chk("stat_req", 128'(STAT_REQ), 128'(0));
      chk("stat_stall", 128'(STAT_STALL), 128'(0));
`endif
      if (m_rst_seen) begin
        chk("rst_bus_valid", 128'(bus_if.BUS_VALID), 128'(0));
        chk("rst_bus_addr", 128'(bus_if.BUS_ADDR), 128'(0));
        chk("rst_bus_wdata", bus_if.BUS_WDATA, 128'(0));
        chk("rst_bus_ctl", 128'({bus_if.BUS_ID, bus_if.BUS_WRITE, bus_if.BUS_LAST}), 128'(0));
        chk("rst_wb", 128'({WB_GPR, WB_DATA}), 128'(0));
      end
      if (bus_if.BUS_VALID) begin
        if (m_beats.size() == 0) begin
          chk("bus_spurious_valid", 128'(1), 128'(0));
        end else begin
          b = m_beats[0];
          chk("bus_id", 128'(bus_if.BUS_ID), 128'(b.id));
          chk("bus_write", 128'(bus_if.BUS_WRITE), 128'(b.wr));
          chk("bus_last", 128'(bus_if.BUS_LAST), 128'(b.last));
          chk("bus_addr", 128'(bus_if.BUS_ADDR), 128'(b.addr));
          chk("bus_wdata", bus_if.BUS_WDATA, b.wdata);
          if (!b.wr) chk("rd_tag_space", 128'(m_tags.size() < RDO), 128'(1));
        end
      end
      if (p_valid && !p_ready) begin
        chk("hold_valid", 128'(bus_if.BUS_VALID), 128'(1));
        chk("hold_addr", 128'({bus_if.BUS_LAST, bus_if.BUS_ADDR}), 128'({p_last, p_addr}));
        chk("hold_wdata", bus_if.BUS_WDATA, p_wdata);
      end
    end

    p_valid = bus_if.BUS_VALID;
    p_ready = bus_if.BUS_READY;
    p_last  = bus_if.BUS_LAST;
    p_addr  = bus_if.BUS_ADDR;
    p_wdata = bus_if.BUS_WDATA;

    if (RST) begin
      m_beats.delete();
      m_tags.delete();
      m_count = 0; m_err = 1'b0; m_wb_v = 1'b0; m_wb_gpr = '0; m_wb_data = '0;
      m_stat_req = 0; m_stat_stall = 0;
      m_started = 1'b1; m_rst_seen = 1'b1; p_valid = 1'b0;
    end else if (m_started) begin
      m_rst_seen = 1'b0;
      pop = 1'b0;
      if (m_count >= DEPTH - 1 && m_stat_stall != 32'hFFFF_FFFF) m_stat_stall++;
      m_wb_v = 1'b0;
      if (RD_VALID) begin
        if (m_tags.size() > 0) begin
          m_wb_v = 1'b1;
          m_wb_gpr = m_tags.pop_front();
          m_wb_data = RD_DATA;
        end else begin
          m_err = 1'b1;
        end
      end
      if (bus_if.BUS_VALID && bus_if.BUS_READY && m_beats.size() > 0) begin
        b = m_beats.pop_front();
        if (!b.wr) begin
          m_tags.push_back(b.src); pop = 1'b1; n_rd_acc++;
        end else if (b.last) begin
          pop = 1'b1; n_wr_acc++;
        end
      end
      if (MEM_nEN != 2'b11) begin
        if (m_count < DEPTH || pop) begin
          if (MEM_WRITE) begin
            m_beats.push_back('{MEM_nEN[0], 1'b1, 1'b0, MEM_ADDR, MEM_DATA_0, MEM_SRC});
            m_beats.push_back('{MEM_nEN[0], 1'b1, 1'b1, MEM_ADDR, MEM_DATA_1, MEM_SRC});
          end else begin
            m_beats.push_back('{MEM_nEN[0], 1'b0, 1'b1, MEM_ADDR, 128'(0), MEM_SRC});
          end
          m_count++;
          if (m_stat_req != 32'hFFFF_FFFF) m_stat_req++;
        end else begin
          m_err = 1'b1;
        end
      end
      if (pop) m_count--;
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [127:0] DA   = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam logic [127:0] DB   = 128'hBBBB_1001_BBBB_1002_BBBB_1003_BBBB_1004;
  localparam logic [127:0] RDAT = 128'hABAB_ABAB_CDCD_CDCD_1234_5678_9ABC_DEF0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] nen, input logic wr, input logic [31:0] a,
                           input logic [5:0] s, input logic [127:0] d0, input logic [127:0] d1);
    MEM_nEN = nen; MEM_WRITE = wr; MEM_ADDR = a; MEM_SRC = s;
    MEM_DATA_0 = d0; MEM_DATA_1 = d1;
  endtask

  task automatic idle_req();
    MEM_nEN = 2'b11; MEM_WRITE = 1'b0; MEM_ADDR = '0; MEM_SRC = '0;
    MEM_DATA_0 = '0; MEM_DATA_1 = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int base;
    RST = 1'b1; RD_VALID = 1'b0; RD_DATA = '0; bus_if.BUS_READY = 1'b0;
    idle_req();
    tick();
    tick();
    RST = 1'b0;
    chk("reset_bus_valid", 128'(bus_if.BUS_VALID), 128'(0));
    chk("reset_stall", 128'(MEM_STALL), 128'(0));
    chk("reset_err", 128'(ERR), 128'(0));
    chk("reset_wb_valid", 128'(WB_VALID), 128'(0));

    // Single read, ready always high
    bus_if.BUS_READY = 1'b1;
    drive_req(2'b00, 1'b0, 32'h100, 6'd5, '0, '0);
    tick();
    idle_req();
    chk("t1_valid", 128'(bus_if.BUS_VALID), 128'(1));
    chk("t1_last", 128'(bus_if.BUS_LAST), 128'(1));
    chk("t1_addr", 128'(bus_if.BUS_ADDR), 128'(32'h100));
    chk("t1_wdata", bus_if.BUS_WDATA, 128'(0));
    tick();
    chk("t1_valid_after", 128'(bus_if.BUS_VALID), 128'(0));
    RD_VALID = 1'b1; RD_DATA = RDAT;
    tick();
    RD_VALID = 1'b0;
    chk("t1_wb_valid", 128'(WB_VALID), 128'(1));
    chk("t1_wb_gpr", 128'(WB_GPR), 128'(5));
    chk("t1_wb_data", WB_DATA, RDAT);
    tick();
    chk("t1_wb_valid_after", 128'(WB_VALID), 128'(0));

    // Two-beat write held off by three not-ready cycles
    bus_if.BUS_READY = 1'b0;
    drive_req(2'b01, 1'b1, 32'h200, 6'd9, DA, DB);
    tick();
    idle_req();
    for (int i = 0; i < 3; i++) begin
      chk("t2_beat0_valid", 128'(bus_if.BUS_VALID), 128'(1));
      chk("t2_beat0_data", bus_if.BUS_WDATA, DA);
      chk("t2_beat0_last", 128'(bus_if.BUS_LAST), 128'(0));
      chk("t2_beat0_id", 128'(bus_if.BUS_ID), 128'(1));
      if (i < 2) tick();
    end
    bus_if.BUS_READY = 1'b1;
    tick();
    chk("t2_beat1_data", bus_if.BUS_WDATA, DB);
    chk("t2_beat1_last", 128'(bus_if.BUS_LAST), 128'(1));
    chk("t2_beat1_addr", 128'(bus_if.BUS_ADDR), 128'(32'h200));
    tick();
    chk("t2_done", 128'(bus_if.BUS_VALID), 128'(0));

    // Overflow: five writes against a stalled bus
    do_reset();
    bus_if.BUS_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_req(2'b10, 1'b1, 32'h300 + 32'(i * 16), 6'(i), DA + 128'(i), DB + 128'(i));
      tick();
      if (i == 1) chk("t3_stall_after2", 128'(MEM_STALL), 128'(0));
      if (i == 2) chk("t3_stall_after3", 128'(MEM_STALL), 128'(1));
      if (i == 3) chk("t3_err_before_drop", 128'(ERR), 128'(0));
    end
    idle_req();
    chk("t3_err", 128'(ERR), 128'(1));
`ifdef MTSP_MEM_QUEUE_STAT_EN
    chk("t3_stat_req", 128'(STAT_REQ), 128'(4));
`else
    chk("t3_stat_req", 128'(STAT_REQ), 128'(0));
`endif
    base = n_wr_acc;
    bus_if.BUS_READY = 1'b1;
    repeat (20) tick();
    chk("t3_writes_issued", 128'(n_wr_acc - base), 128'(4));
    chk("t3_drained_stall", 128'(MEM_STALL), 128'(0));
    chk("t3_err_sticky", 128'(ERR), 128'(1));

    // Outstanding-read limit
    do_reset();
    bus_if.BUS_READY = 1'b1;
    base = n_rd_acc;
    for (int i = 0; i < 5; i++) begin
      drive_req(2'b00, 1'b0, 32'h400 + 32'(i * 4), 6'(10 + i), '0, '0);
      tick();
    end
    idle_req();
    repeat (20) tick();
    chk("t4_reads_before", 128'(n_rd_acc - base), 128'(4));
    chk("t4_blocked_idle", 128'(bus_if.BUS_VALID), 128'(0));
    RD_VALID = 1'b1; RD_DATA = RDAT;
    tick();
    RD_VALID = 1'b0;
    chk("t4_wb_gpr", 128'(WB_GPR), 128'(10));
    repeat (5) tick();
    chk("t4_reads_after", 128'(n_rd_acc - base), 128'(5));

    // Return with no outstanding read
    do_reset();
    RD_VALID = 1'b1; RD_DATA = RDAT;
    tick();
    RD_VALID = 1'b0;
    chk("t6_wb_none", 128'(WB_VALID), 128'(0));
    chk("t6_err", 128'(ERR), 128'(1));

    // Reset between the two write beats
    do_reset();
    bus_if.BUS_READY = 1'b1;
    drive_req(2'b00, 1'b1, 32'h500, 6'd3, DA, DB);
    tick();
    idle_req();
    tick();
    chk("t5_beat1_shown", 128'(bus_if.BUS_LAST), 128'(1));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t5_valid", 128'(bus_if.BUS_VALID), 128'(0));
    chk("t5_addr", 128'(bus_if.BUS_ADDR), 128'(0));
    chk("t5_wdata", bus_if.BUS_WDATA, 128'(0));
    chk("t5_ctl", 128'({bus_if.BUS_ID, bus_if.BUS_WRITE, bus_if.BUS_LAST}), 128'(0));
    chk("t5_stall_err_wb", 128'({MEM_STALL, ERR, WB_VALID}), 128'(0));
    chk("t5_stat_req", 128'(STAT_REQ), 128'(0));
    repeat (4) tick();
    chk("t5_no_beat1", 128'(bus_if.BUS_VALID), 128'(0));

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mtsp_mem_queue.md
MTSP_MEM_QUEUE -- requirements
Module: mtsp_mem_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning request FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter RD_OUTSTANDING, default 4, meaning max issued-but-unreturned reads (power of two).
REQ-003 SHALL have port CLK  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports MEM_nEN in 2 (active-low target select, 2'b11 = idle), MEM_WRITE in 1, MEM_ADDR in 32, MEM_SRC in 6 (GPR index): the upstream execute-stage memory request.
REQ-006 SHALL have ports MEM_DATA_0, MEM_DATA_1  in  128 each  write data, two beats.
REQ-007 SHALL have port MEM_STALL  out  1  back-pressure to the execute stage.
REQ-008 SHALL have bus ports BUS_VALID out 1, BUS_READY in 1, BUS_ID out 1, BUS_WRITE out 1, BUS_LAST out 1, BUS_ADDR out 32, BUS_WDATA out 128.
REQ-009 SHALL have ports RD_VALID in 1, RD_DATA in 128: in-order read return, no back-pressure.
REQ-010 SHALL have ports WB_VALID out 1, WB_GPR out 6, WB_DATA out 128: register write-back.
REQ-011 SHALL have ports ERR out 1 (sticky), STAT_REQ out 32, STAT_STALL out 32.

Function
REQ-012 SHALL push {id, write, addr, src, data0, data1} when MEM_nEN!=2'b11 and (count<DEPTH or a pop occurs the same cycle); MEM_nEN=2'b00 maps to id 0.
REQ-013 SHALL drop a request arriving while full with no same-cycle pop, and set ERR.
REQ-014 SHALL drive MEM_STALL=1 combinationally from registered count>=DEPTH-1.
REQ-015 SHALL run issue FSM IDLE->RD or WR0 on non-empty FIFO head; RD->IDLE on accept; WR0->WR1 on accept; WR1->IDLE on accept.
REQ-016 SHALL raise BUS_VALID the cycle after a push into an empty FIFO with FSM in IDLE (1-cycle latency).
REQ-017 SHALL hold all BUS_* outputs stable while BUS_VALID=1 and BUS_READY=0.
REQ-018 SHALL issue writes as two beats, same BUS_ADDR: beat0 BUS_WDATA=data0, LAST=0; beat1 BUS_WDATA=data1, LAST=1; pop after beat1 accept.
REQ-019 SHALL issue reads as one beat, LAST=1, BUS_WDATA=0; pop and push src into tag FIFO on accept.
REQ-020 SHALL not leave IDLE for a read while the tag FIFO holds RD_OUTSTANDING entries; writes are not blocked.
REQ-021 SHALL register WB_VALID=1, WB_GPR=tag head, WB_DATA=RD_DATA one cycle after RD_VALID, popping the tag.
REQ-022 SHALL ignore RD_VALID with an empty tag FIFO (no WB_VALID) and set ERR.
REQ-023 SHALL keep ERR set until RST.

Reset
REQ-024 SHALL on RST clear both FIFOs, FSM to IDLE, ERR, counters; all outputs 0 (MEM_STALL 0) the following cycle.
REQ-025 SHALL abandon an in-flight write burst on RST: no beat1, no further BUS_VALID until a new push.

Configuration
REQ-026 SHALL with MTSP_MEM_QUEUE_STAT_EN defined count STAT_REQ per accepted push and STAT_STALL per MEM_STALL cycle, saturating at 32'hFFFFFFFF.
REQ-027 SHALL without MTSP_MEM_QUEUE_STAT_EN tie STAT_REQ and STAT_STALL to 0 and synthesize no counter logic.

Structure
REQ-028 SHALL place entry struct, FSM state enum, and width constants (ADDR 32, DATA 128, GPR 6) in the shared MTSP package.
REQ-029 SHALL instantiate one generic sub-module mtsp_sync_fifo twice: request FIFO and read-tag FIFO.

Verification
REQ-030 Read, addr 0x100, src 5, BUS_READY=1 -> BUS_VALID next cycle, LAST=1; RD_VALID with 0xAB.. -> WB_VALID next cycle, WB_GPR=5.
REQ-031 Write, addr 0x200, data0=A, data1=B, BUS_READY low 3 cycles -> beat0 held 3 cycles, then beat1 B with LAST=1, same addr.
REQ-032 5 pushes, BUS_READY=0, DEPTH=4 -> MEM_STALL after 3rd, 5th dropped, ERR=1, only 4 requests issued.
REQ-033 5 reads, no RD_VALID -> exactly 4 accepted, 5th waits; one RD_VALID -> 5th issues.
REQ-034 RST asserted after write beat0 accept -> no beat1, all outputs 0; STAT_REQ=0 with macro, 0 without.
